// File: rtl/dmem_responder.sv
// Data-memory responder: target end of the core's mem_d_* request/ack port.
// Serves reads, byte-masked writes and cache-maintenance requests from an
// internal word RAM and returns one tagged response per accepted request
// after exactly LATENCY cycles.
module dmem_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h80000000,
  parameter int          MEM_WORDS = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_wr_i,
  input  logic        mem_rd_i,
  input  logic [3:0]  mem_wr_i,
  input  logic        mem_cacheable_i,
  input  logic [10:0] mem_req_tag_i,
  input  logic        mem_invalidate_i,
  input  logic        mem_writeback_i,
  input  logic        mem_flush_i,
  input  logic        stall_i,
  output logic        mem_accept_o,
  output logic        mem_ack_o,
  output logic        mem_error_o,
  output logic [10:0] mem_resp_tag_o,
  output logic [31:0] mem_data_rd_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [31:0] r_mem [MEM_WORDS];

  logic              r_vld [LATENCY];
  logic [10:0]       r_tag [LATENCY];
  logic              r_err [LATENCY];
  logic [31:0]       r_dat [LATENCY];

  logic              w_wr_any;
  logic              w_req_valid;
  logic              w_take;
  logic [31:0]       w_offset;
  logic [IDX_W-1:0]  w_idx;
  logic              w_in_range;
  logic              w_err;
  logic              w_do_wr;
  logic [31:0]       w_rsp_data;
  logic              w_unused_ok;

  assign w_wr_any    = |mem_wr_i;
  assign w_req_valid = mem_rd_i | w_wr_any | mem_invalidate_i | mem_writeback_i | mem_flush_i;
  assign mem_accept_o = !rst_i && !stall_i;
  assign w_take      = w_req_valid && mem_accept_o;

  // Offset is only meaningful when addr >= base, which the range test
  // requires first, so the 32-bit subtract never sees a wrapped result.
  assign w_offset   = mem_addr_i - ADDR_BASE;
  assign w_in_range = (mem_addr_i >= ADDR_BASE) && (w_offset[31:IDX_W+2] == '0);
  assign w_idx      = w_offset[IDX_W+1:2];

  // Read+write together is malformed; address errors only apply to data ops,
  // maintenance-only requests skip the address check entirely.
  assign w_err      = (mem_rd_i && w_wr_any) || ((mem_rd_i || w_wr_any) && !w_in_range);
  assign w_do_wr    = w_wr_any && !w_err;
  assign w_rsp_data = (mem_rd_i && !w_err) ? r_mem[w_idx] : 32'h0;

  assign w_unused_ok = &{1'b0, mem_cacheable_i, w_offset[1:0]};

  // RAM byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (w_take && w_do_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wr_i[b]) begin
          r_mem[w_idx][8*b +: 8] <= mem_data_wr_i[8*b +: 8];
        end
      end
    end
  end

  // Response shift pipeline; reset drops everything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_vld[i] <= 1'b0;
        r_tag[i] <= '0;
        r_err[i] <= 1'b0;
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_take;
      r_tag[0] <= w_take ? mem_req_tag_i : 11'h0;
      r_err[0] <= w_take && w_err;
      r_dat[0] <= w_take ? w_rsp_data : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
        r_err[i] <= r_err[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  // Outputs are forced to zero whenever no response is presented.
  assign mem_ack_o      = r_vld[LATENCY-1] && !rst_i;
  assign mem_error_o    = mem_ack_o && r_err[LATENCY-1];
  assign mem_resp_tag_o = mem_ack_o ? r_tag[LATENCY-1] : 11'h0;
  assign mem_data_rd_o  = mem_ack_o ? r_dat[LATENCY-1] : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 7) share one
// stimulus stream; a behavioural model predicts every response and a
// negedge process compares all outputs every cycle.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h80000000;
  localparam int          WORDS = 1024;
  localparam int          LAT [3] = '{2, 1, 7};

  logic        clk = 1'b0;
  logic        rst, rd, cach, inv, wb, fl, stall;
  logic [3:0]  wr;
  logic [31:0] addr, wdata;
  logic [10:0] tag;

  logic        acc [3];
  logic        ack [3];
  logic        err [3];
  logic [10:0] rtag [3];
  logic [31:0] rdat [3];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_BASE(BASE), .MEM_WORDS(WORDS), .LATENCY(2)) u_l2 (
    .clk_i(clk), .rst_i(rst), .mem_addr_i(addr), .mem_data_wr_i(wdata), .mem_rd_i(rd),
    .mem_wr_i(wr), .mem_cacheable_i(cach), .mem_req_tag_i(tag), .mem_invalidate_i(inv),
    .mem_writeback_i(wb), .mem_flush_i(fl), .stall_i(stall), .mem_accept_o(acc[0]),
    .mem_ack_o(ack[0]), .mem_error_o(err[0]), .mem_resp_tag_o(rtag[0]), .mem_data_rd_o(rdat[0]));

  dmem_responder #(.ADDR_BASE(BASE), .MEM_WORDS(WORDS), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_i(rst), .mem_addr_i(addr), .mem_data_wr_i(wdata), .mem_rd_i(rd),
    .mem_wr_i(wr), .mem_cacheable_i(cach), .mem_req_tag_i(tag), .mem_invalidate_i(inv),
    .mem_writeback_i(wb), .mem_flush_i(fl), .stall_i(stall), .mem_accept_o(acc[1]),
    .mem_ack_o(ack[1]), .mem_error_o(err[1]), .mem_resp_tag_o(rtag[1]), .mem_data_rd_o(rdat[1]));

  dmem_responder #(.ADDR_BASE(BASE), .MEM_WORDS(WORDS), .LATENCY(7)) u_l7 (
    .clk_i(clk), .rst_i(rst), .mem_addr_i(addr), .mem_data_wr_i(wdata), .mem_rd_i(rd),
    .mem_wr_i(wr), .mem_cacheable_i(cach), .mem_req_tag_i(tag), .mem_invalidate_i(inv),
    .mem_writeback_i(wb), .mem_flush_i(fl), .stall_i(stall), .mem_accept_o(acc[2]),
    .mem_ack_o(ack[2]), .mem_error_o(err[2]), .mem_resp_tag_o(rtag[2]), .mem_data_rd_o(rdat[2]));

  typedef struct {
    int          due;
    logic [10:0] tag;
    logic        err;
    logic [31:0] data;
  } resp_t;

  resp_t       q [3][$];
  logic [31:0] mmem [int];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          ack_cnt [3] = '{0, 0, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // ---------------- behavioural model: one response per accepted request
  resp_t       mr;
  logic [63:0] m_off;
  logic        m_in;
  int          m_w;
  logic [31:0] m_tmp;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      for (int k = 0; k < 3; k++) q[k].delete();
    end else if (!stall && (rd || (|wr) || inv || wb || fl)) begin
      m_off   = {32'h0, addr} - {32'h0, BASE};
      m_in    = (addr >= BASE) && (m_off < 64'(4 * WORDS));
      m_w     = int'(m_off >> 2);
      mr.tag  = tag;
      mr.err  = 1'b0;
      mr.data = 32'h0;
      if (rd && (|wr)) mr.err = 1'b1;
      else if ((rd || (|wr)) && !m_in) mr.err = 1'b1;
      else if (|wr) begin
        m_tmp = mmem.exists(m_w) ? mmem[m_w] : 32'h0;
        for (int b = 0; b < 4; b++) if (wr[b]) m_tmp[8*b +: 8] = wdata[8*b +: 8];
        mmem[m_w] = m_tmp;
      end else if (rd) mr.data = mmem.exists(m_w) ? mmem[m_w] : 32'h0;
      for (int k = 0; k < 3; k++) begin
        mr.due = cyc + LAT[k] - 1;
        q[k].push_back(mr);
      end
    end
  end

  // ---------------- per-cycle compare of every instance against the model
  logic        e_ack, e_err;
  logic [10:0] e_tag;
  logic [31:0] e_dat;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      e_ack = 1'b0; e_err = 1'b0; e_tag = 11'h0; e_dat = 32'h0;
      if (!rst && q[k].size() > 0 && q[k][0].due < cyc) begin
        chk($sformatf("missed_ack L%0d tag", LAT[k]), 32'(q[k][0].tag), 32'hFFFFFFFF);
        void'(q[k].pop_front());
      end
      if (!rst && q[k].size() > 0 && q[k][0].due == cyc) begin
        e_ack = 1'b1;
        e_tag = q[k][0].tag;
        e_err = q[k][0].err;
        e_dat = q[k][0].data;
        void'(q[k].pop_front());
      end
      chk($sformatf("accept L%0d", LAT[k]), 32'(acc[k]), 32'(!rst && !stall));
      chk($sformatf("ack L%0d", LAT[k]),    32'(ack[k]), 32'(e_ack));
      chk($sformatf("error L%0d", LAT[k]),  32'(err[k]), 32'(e_err));
      chk($sformatf("tag L%0d", LAT[k]),    32'(rtag[k]), 32'(e_tag));
      chk($sformatf("data L%0d", LAT[k]),   rdat[k], e_dat);
      if (ack[k] === 1'b1) ack_cnt[k]++;
    end
  end

  // ---------------- stimulus helpers
  task automatic idle();
    rd = 1'b0; wr = 4'h0; inv = 1'b0; wb = 1'b0; fl = 1'b0;
    addr = 32'h0; wdata = 32'h0; tag = 11'h0; cach = 1'b0;
  endtask

  task automatic req(input logic r, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d, input logic [10:0] t, input logic [2:0] m,
                     output int acc_c);
    rd = r; wr = w; addr = a; wdata = d; tag = t; {inv, wb, fl} = m; cach = ~cach;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      if (!rst && !stall) begin
        #1;
        acc_c = cyc;
        return;
      end
    end
    chk("accept_timeout", 32'h0, 32'h1);
    acc_c = -1;
    #1;
  endtask

  // Literal pin on the LATENCY=2 instance: waits for the tagged ack.
  task automatic wait_ack(input logic [10:0] t, input int acc_c, input logic [31:0] d,
                          input logic e, input string nm);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (ack[0] === 1'b1 && rtag[0] === t) begin
        chk({nm, "_data"}, rdat[0], d);
        chk({nm, "_err"}, 32'(err[0]), 32'(e));
        chk({nm, "_lat"}, 32'(cyc - acc_c), 32'd1);
        return;
      end
    end
    chk({nm, "_ack_timeout"}, 32'h0, 32'h1);
  endtask

  int a0, a1, s0;
  int snap [3];

  initial begin
    rst = 1'b1; stall = 1'b0; cach = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // full-word write then read, back to back
    req(1'b0, 4'hF, 32'h80000010, 32'hDEADBEEF, 11'd5, 3'b000, a0);
    req(1'b1, 4'h0, 32'h80000010, 32'h0, 11'd6, 3'b000, a1);
    idle();
    wait_ack(11'd5, a0, 32'h0, 1'b0, "wr5");
    wait_ack(11'd6, a1, 32'hDEADBEEF, 1'b0, "rd6");

    // byte-masked write
    req(1'b0, 4'b0101, 32'h80000010, 32'h11223344, 11'd7, 3'b000, a0);
    idle();
    wait_ack(11'd7, a0, 32'h0, 1'b0, "wr7");
    req(1'b1, 4'h0, 32'h80000012, 32'h0, 11'd8, 3'b000, a0);
    idle();
    wait_ack(11'd8, a0, 32'hDE22BE44, 1'b0, "mask8");

    // out-of-range and malformed requests
    req(1'b1, 4'h0, 32'h7FFFFFFC, 32'h0, 11'd9, 3'b000, a0);
    idle();
    wait_ack(11'd9, a0, 32'h0, 1'b1, "below9");
    req(1'b1, 4'h0, 32'h80001000, 32'h0, 11'd10, 3'b000, a0);
    idle();
    wait_ack(11'd10, a0, 32'h0, 1'b1, "above10");
    req(1'b0, 4'hF, 32'hFFFFFFFC, 32'h12345678, 11'd11, 3'b000, a0);
    idle();
    wait_ack(11'd11, a0, 32'h0, 1'b1, "wrap11");
    req(1'b1, 4'h1, 32'h80000010, 32'hFFFFFFFF, 11'd12, 3'b000, a0);
    idle();
    wait_ack(11'd12, a0, 32'h0, 1'b1, "rdwr12");
    req(1'b1, 4'h0, 32'h80000010, 32'h0, 11'd13, 3'b000, a0);
    idle();
    wait_ack(11'd13, a0, 32'hDE22BE44, 1'b0, "keep13");

    // last word of the RAM
    req(1'b0, 4'hF, 32'h80000FFC, 32'hCAFEF00D, 11'd14, 3'b000, a0);
    req(1'b1, 4'h0, 32'h80000FFC, 32'h0, 11'd15, 3'b000, a1);
    idle();
    wait_ack(11'd14, a0, 32'h0, 1'b0, "wrlast14");
    wait_ack(11'd15, a1, 32'hCAFEF00D, 1'b0, "rdlast15");

    // back-to-back writes then four back-to-back reads
    for (int i = 0; i < 4; i++)
      req(1'b0, 4'hF, 32'h80000020 + 32'(4 * i), 32'hA0A0A000 + 32'(i), 11'(20 + i), 3'b000, a0);
    idle();
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) snap[k] = ack_cnt[k];
    for (int i = 0; i < 4; i++)
      req(1'b1, 4'h0, 32'h80000020 + 32'(4 * i), 32'h0, 11'(1 + i), 3'b000, a0);
    idle();
    repeat (12) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("b2b_count L%0d", LAT[k]), 32'(ack_cnt[k] - snap[k]), 32'd4);

    // stall holds a read for 3 cycles
    stall = 1'b1;
    s0 = cyc;
    fork
      req(1'b1, 4'h0, 32'h80000024, 32'h0, 11'd30, 3'b000, a0);
      begin
        repeat (3) @(posedge clk);
        #1 stall = 1'b0;
      end
    join
    idle();
    chk("stall_accept_cycle", 32'(a0 - s0), 32'd4);
    wait_ack(11'd30, a0, 32'hA0A0A001, 1'b0, "stall30");

    // stall raised while a response is in flight
    req(1'b1, 4'h0, 32'h8000002C, 32'h0, 11'd31, 3'b000, a0);
    stall = 1'b1;
    idle();
    wait_ack(11'd31, a0, 32'hA0A0A003, 1'b0, "inflight31");
    #1 stall = 1'b0;

    // maintenance-only flush, address ignored
    req(1'b0, 4'h0, 32'h00000000, 32'h0, 11'h7FF, 3'b001, a0);
    idle();
    wait_ack(11'h7FF, a0, 32'h0, 1'b0, "flush7ff");
    req(1'b0, 4'h0, 32'h12345678, 32'h0, 11'h155, 3'b100, a0);
    idle();
    wait_ack(11'h155, a0, 32'h0, 1'b0, "inval155");

    // reset right after an accept drops the response; RAM survives
    repeat (8) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) snap[k] = ack_cnt[k];
    req(1'b1, 4'h0, 32'h80000010, 32'h0, 11'd40, 3'b000, a0);
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("rst_drop L%0d", LAT[k]), 32'(ack_cnt[k] - snap[k]), 32'd0);
    req(1'b1, 4'h0, 32'h80000010, 32'h0, 11'd41, 3'b000, a0);
    idle();
    wait_ack(11'd41, a0, 32'hDE22BE44, 1'b0, "postrst41");
    req(1'b1, 4'h0, 32'h80000FFC, 32'h0, 11'd42, 3'b000, a0);
    idle();
    wait_ack(11'd42, a0, 32'hCAFEF00D, 1'b0, "postrst42");

    repeat (10) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
